// File: rtl/bin2bcd_pkg.sv
// Shared constants and FSM state type for the 8-bit binary to BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bin2bcd_pkg;

    localparam int BIN_W  = 8;                  // binary input width
    localparam int DIGITS = 3;                  // BCD digits produced
    localparam int BCD_W  = 4 * DIGITS;         // packed BCD result width
    localparam int WORK_W = BCD_W + BIN_W;      // double-dabble working register (20)
    localparam int CNT_W  = 4;                  // shift-step counter width

    // Counter value during the final shift step (steps are numbered 0..7).
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5..9 gets +3 before the shift.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_dig  - BCD digit taken from the working register
//   o_dig  - corrected digit (i_dig + 3 when i_dig >= 5, else i_dig)
module bcd_add3 (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    // Digits never exceed 9 before correction, so the sum (max 12) fits in 4 bits.
    assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/bin2bcd_8.sv
// Sequential double-dabble converter: 8-bit unsigned binary to 3 packed BCD digits.
// Latency: start sampled at edge N, done pulses (with bcd valid) in the cycle after edge N+8.
// Backpressure: none; start events while busy or done are dropped, not queued.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   init   - start request, level input; a start is init rising (init=1 while the
//            registered copy is 0)
//   bin    - value to convert, sampled only on the start edge
//   bcd    - {hundreds, tens, units}; holds the last result until the next completion
//   busy   - high while the eight shift steps are in progress
//   done   - one-cycle completion pulse
module bin2bcd_8 #(
    // Only the defaults (8 bits, 3 digits) are supported; the working register
    // width comes from the package.
    parameter int BIN_W  = bin2bcd_pkg::BIN_W,
    parameter int DIGITS = bin2bcd_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    import bin2bcd_pkg::*;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_init_q;
    logic [WORK_W-1:0]      r_work;
    logic [CNT_W-1:0]       r_cnt;
    logic [4*DIGITS-1:0]    r_bcd;
    logic                   r_busy;
    logic                   r_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic [WORK_W-1:0]      w_work_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [4*DIGITS-1:0]    w_bcd_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    logic                   w_start;
    logic [WORK_W-1:0]      w_adj;
    logic [WORK_W-1:0]      w_shift;

    assign w_start = init & ~r_init_q;

    // Correct every BCD digit of the working register, then shift left by one.
    // The binary part below the digits passes through unchanged.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .i_dig (r_work[BIN_W + 4*g +: 4]),
            .o_dig (w_adj [BIN_W + 4*g +: 4])
        );
    end
    assign w_adj[BIN_W-1:0] = r_work[BIN_W-1:0];
    assign w_shift          = {w_adj[WORK_W-2:0], 1'b0};

    // ------------------------------------------------------------------
    // FSM: next state, datapath and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_bcd_nxt   = r_bcd;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_work_nxt  = {{(4*DIGITS){1'b0}}, bin};
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_work_nxt = w_shift;
                w_cnt_nxt  = r_cnt + 1'b1;
                // The final shift result goes straight to bcd so it is valid
                // in the same cycle as done.
                if (r_cnt == LAST_STEP) begin
                    w_bcd_nxt   = w_shift[WORK_W-1:BIN_W];
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_init_q <= 1'b0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_bcd    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_init_q <= init;
            r_work   <= w_work_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bcd    <= w_bcd_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_bin2bcd_8.sv
// Self-checking bench for bin2bcd_8 against an arithmetic decimal-digit model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bin2bcd_8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        init  = 1'b0;
    logic [7:0]  bin   = 8'd0;
    logic [11:0] bcd;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    bin2bcd_8 #(.BIN_W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (init),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits of v by plain division.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One conversion of v. init stays high for 'hold' cycles; bin changes to
    // chg_v after observation k == chg_k; glitch re-raises init during SHIFT;
    // pre_rst starts the conversion straight out of reset with init already high.
    // Observation k is taken at the falling edge following rising edge N+k.
    task automatic conv(input string tag, input int v, input int hold,
                        input int chg_k, input int chg_v, input bit glitch,
                        input bit pre_rst);
        logic [11:0] exp_b;
        logic [11:0] first;
        int busy_n, done_n, done_k;
        bit moved;
        exp_b  = ref_bcd(v);
        first  = '0;
        busy_n = 0;
        done_n = 0;
        done_k = -1;
        moved  = 1'b0;
        @(negedge clk);
        bin  = v[7:0];
        init = 1'b1;
        if (pre_rst) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 0) first = bcd;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    check({tag, "_bcd"}, 32'(bcd), 32'(exp_b));
                end
            end else if (k < 8 && bcd !== first) begin
                moved = 1'b1;
            end
            if (k == hold - 1) init = 1'b0;
            if (k == chg_k)    bin  = chg_v[7:0];
            if (glitch && k == 2) init = 1'b1;
            if (glitch && k == 4) init = 1'b0;
        end
        init = 1'b0;
        check({tag, "_done_cnt"},  32'(done_n), 32'd1);
        check({tag, "_done_cyc"},  32'(done_k), 32'd8);
        check({tag, "_busy_cyc"},  32'(busy_n), 32'd8);
        check({tag, "_bcd_held"},  32'(moved),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n;
        int v, h, ck;

        // Reset state
        #12;
        check("rst_bcd",  32'(bcd),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values
        conv("v9",   9,   1, -1, 0, 1'b0, 1'b0);
        conv("v225", 225, 1, -1, 0, 1'b0, 1'b0);
        conv("v0",   0,   1, -1, 0, 1'b0, 1'b0);
        conv("v255", 255, 1, -1, 0, 1'b0, 1'b0);

        // Reset in the middle of a conversion of 200 (after the 4th step)
        @(negedge clk);
        bin  = 8'd200;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd",  32'(bcd),  32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);

        // Long init, bin changes during SHIFT, second rising edge during SHIFT
        conv("hold2",   37,  2,  -1, 0,  1'b0, 1'b0);
        conv("hold20",  180, 20, -1, 0,  1'b0, 1'b0);
        conv("binchg",  123, 1,  3,  77, 1'b0, 1'b0);
        conv("glitch",  64,  1,  -1, 0,  1'b1, 1'b0);
        // init already high when reset releases
        conv("rst_init", 42, 1,  -1, 0,  1'b0, 1'b1);

        // Exhaustive sweep
        for (int i = 0; i < 256; i++)
            conv("sweep", i, 1, -1, 0, 1'b0, 1'b0);

        // Randomized value, init hold length and bin disturbance
        for (int i = 0; i < 30; i++) begin
            v  = int'($urandom_range(255, 0));
            h  = int'($urandom_range(15, 1));
            ck = int'($urandom_range(9, 0));
            conv("rand", v, h, ck, int'($urandom_range(255, 0)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_8.md
BIN2BCD_8 -- requirements
Module: bin2bcd_8

Interface
REQ-001 SHALL have parameter BIN_W, default 8, binary input width; only 8 is supported.
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD output digits; only 3 is supported.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port init, input, 1, conversion start request (level input, rising-edge qualified).
REQ-006 SHALL have port bin, input, 8, unsigned binary value to convert (the multiplier product pp).
REQ-007 SHALL have port bcd, output, 12, packed result: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-008 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-010 SHALL implement a sequential double-dabble converter: one shift step per clock, 8 steps per conversion.
REQ-011 SHALL register init into init_q every cycle; a start event is init=1 AND init_q=0 at a rising edge.
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE: on a start event at edge N, SHALL load the 20-bit working register with {12'b0, bin}, clear the step counter, go to SHIFT and set busy=1.
REQ-014 SHIFT step, per edge: SHALL add 3 to each BCD digit of the working register that is >=5, then shift the whole register left by 1 and increment the counter.
REQ-015 After the 8th shift (edge N+8), SHALL copy working[19:8] to bcd, go to DONE, clear busy and set done=1.
REQ-016 DONE: SHALL go to IDLE at the next edge (N+9) and clear done; done is high for exactly one cycle.
REQ-017 Latency: done SHALL be high in the cycle after edge N+8, with bcd valid in that same cycle.
REQ-018 bcd SHALL hold its last result until the next completion; it SHALL NOT change during SHIFT.
REQ-019 bin SHALL be sampled only at edge N; changes to bin during SHIFT SHALL have no effect.
REQ-020 Start events while in SHIFT or DONE SHALL be ignored and not queued.
REQ-021 init held high for multiple cycles SHALL produce exactly one conversion; a new one requires init to go low, then high.
REQ-022 Every digit of bcd SHALL be in the range 0..9; the hundreds digit SHALL be <=2.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, bcd=12'h000, busy=0, done=0, init_q=0, counter=0 and the working register to 0.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion, with no done pulse after release.
REQ-025 After rst_n deasserts, init already high SHALL count as a start event at the first rising edge, because init_q=0.

Structure
REQ-026 Package bin2bcd_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), BIN_W=8, DIGITS=3, WORK_W=20 and the step-counter width (4).
REQ-027 SHALL use one sub-module, bcd_add3: a 4-bit combinational "if >=5 add 3" cell, instantiated DIGITS times.
REQ-028 All outputs SHALL be driven directly from registers.

Verification
REQ-029 Reset, then init rising edge with bin=8'd9 (3*3) -> done at edge N+8, bcd=12'h009, busy high for exactly 8 cycles.
REQ-030 bin=8'd225 (15*15) -> bcd=12'h225; then bin=8'd0 -> bcd=12'h000; then bin=8'd255 -> bcd=12'h255.
REQ-031 init held high 2 cycles, then 20 cycles -> exactly one done pulse each time; bin changed to 8'd77 during SHIFT -> result still reflects the value sampled at edge N.
REQ-032 rst_n pulsed low at step 4 of a conversion of bin=8'd200 -> bcd=12'h000 immediately, busy=0, no done pulse.
REQ-033 Second init rising edge during SHIFT -> ignored, single done; exhaustive sweep bin=0..255 -> bcd equals the decimal digits of bin for all 256 values.
